lock_state_controller: RTL
==========================

// Module: lock_state_controller
// PURPOSE
//   Parametrised door-lock control FSM. Sequences power-on, digit entry,
//   password check, door open, password change, and lockout after repeated
//   failures. Adds digit counting, an inactivity timeout, an open-door timer
//   and a lockout timer. Sits between the keypad decoder and the password
//   compare/storage block; its state drives the display and the actuator.
// PARAMETERS
//   PW_LEN          4     password length in digits (1..15)
//   MAX_FAIL        3     consecutive failed checks that trigger LOCKOUT (1..15)
//   IDLE_TIMEOUT    500   clk cycles without a key event before ENTRY/SET_PW/CHECK abort
//   OPEN_CYCLES     200   clk cycles the door stays unlocked
//   LOCKOUT_CYCLES  1000  clk cycles of lockout
//   TW = $clog2(max(IDLE_TIMEOUT, OPEN_CYCLES, LOCKOUT_CYCLES) + 1)  (localparam, timer width)
// PORTS
//   clk              in   1   system clock, rising edge
//   reset            in   1   asynchronous, active-high reset
//   is_on            in   1   power switch level
//   digit_strobe     in   1   1-cycle pulse: digit key pressed
//   is_star_pressed  in   1   1-cycle pulse: '*' (submit) pressed
//   clear_key        in   1   1-cycle pulse: user clear of the current entry
//   initialize       in   1   1-cycle pulse: request password change
//   cmp_valid        in   1   compare block result valid
//   correct          in   1   compare result; sampled only when cmp_valid=1
//   state            out  3   FSM state code (registered)
//   digit_count      out  4   digits accepted in the current entry
//   fail_count       out  4   consecutive failures
//   unlock           out  1   door actuator; high exactly while state==OPEN
//   alarm            out  1   high exactly while state==LOCKOUT
//   cmp_req          out  1   1-cycle pulse on entry to CHECK
//   pw_store         out  1   1-cycle pulse: store buffer as the new password
//   clear_buffer     out  1   1-cycle pulse: digit buffer must be cleared
// BEHAVIOUR
//   Reset: state=OFF, all counters, timers and outputs 0. Reset mid-operation
//     aborts everything immediately. All outputs are registered.
//   Codes: OFF=000 IDLE=001 ENTRY=010 CHECK=011 OPEN=100 SET_PW=101 LOCKOUT=110.
//   Any undefined code goes to OFF on the next clk.
//   Precedence: is_on=0 forces OFF from every state except LOCKOUT, and
//     pulses clear_buffer. LOCKOUT always runs to completion.
//   Timer: TW-bit down-counter. Reloads on every state change and on every
//     digit_strobe, clear_key or is_star_pressed event.
//   OFF:     is_on=1 -> IDLE.
//   IDLE:    digit_strobe -> ENTRY with digit_count=1. All other inputs ignored.
//   ENTRY:   digit_strobe increments digit_count, saturating at PW_LEN.
//            is_star_pressed -> CHECK and pulses cmp_req; a digit_strobe in the
//            same cycle is dropped. clear_key -> digit_count=0 and clear_buffer
//            pulse; state stays ENTRY. Timer expiry -> IDLE, digit_count=0,
//            clear_buffer pulse.
//   CHECK:   Waits for cmp_valid.
//            Pass (correct=1 and digit_count==PW_LEN): OPEN, fail_count=0.
//            Fail (any other result, or timer expiry): fail_count+1. If the new
//            count equals MAX_FAIL -> LOCKOUT, otherwise -> IDLE.
//            On leaving CHECK: digit_count=0 and clear_buffer pulse.
//   OPEN:    Runs OPEN_CYCLES, then -> IDLE.
//            initialize -> SET_PW with digit_count=0.
//   SET_PW:  Digits count as in ENTRY.
//            is_star_pressed with digit_count==PW_LEN -> pw_store pulse, -> IDLE.
//            is_star_pressed with a short entry -> digit_count=0, clear_buffer
//            pulse, stay in SET_PW.
//            Timer expiry -> IDLE without pw_store.
//   LOCKOUT: Key inputs are ignored. After LOCKOUT_CYCLES -> fail_count=0;
//            next state is IDLE if is_on=1, otherwise OFF.
//   Arithmetic: digit_count and fail_count saturate. The timer never wraps;
//     it holds at 0 until reloaded.
// TESTING (PW_LEN=4, MAX_FAIL=3, IDLE_TIMEOUT=10, OPEN_CYCLES=8, LOCKOUT_CYCLES=20)
//   1. reset, is_on=1, 4 digits, '*', cmp_valid=1/correct=1 -> cmp_req once;
//      OPEN; unlock=1 for 8 cycles; then IDLE.
//   2. Three wrong entries -> fail_count 1,2,3; LOCKOUT, alarm=1.
//      Digits during lockout are ignored. After 20 cycles: IDLE, fail_count=0.
//   3. 6 digits -> digit_count=4. '*' + correct=1 -> OPEN.
//      3 digits + '*' + correct=1 -> fail path (IDLE, fail_count=1).
//   4. 2 digits, then 10 idle cycles -> IDLE, clear_buffer pulse, digit_count=0.
//   5. In OPEN: initialize, 3 digits, '*' -> stays SET_PW, no pw_store.
//      Then 4 digits, '*' -> pw_store pulse, IDLE.
//   6. is_on=0 in ENTRY -> OFF next cycle. is_on=0 in LOCKOUT -> stays LOCKOUT.
//      Reset asserted mid-CHECK -> OFF immediately.

Source files
------------

// File: rtl/lock_state_controller.sv
// -----------------------------------------------------------------------------
// lock_state_controller
//   Door-lock control FSM. Sequences power-on, digit entry, password check,
//   door open, password change and lockout after repeated failures. One shared
//   down-counter serves as the inactivity timeout (ENTRY/SET_PW/CHECK), the
//   open-door timer (OPEN) and the lockout timer (LOCKOUT).
//
// Ports
//   clk              in   1  system clock, rising edge
//   reset            in   1  asynchronous, active-high reset
//   is_on            in   1  power switch level
//   digit_strobe     in   1  pulse: digit key pressed
//   is_star_pressed  in   1  pulse: '*' (submit) pressed
//   clear_key        in   1  pulse: clear the current entry
//   initialize       in   1  pulse: request password change (OPEN only)
//   cmp_valid        in   1  compare result valid
//   correct          in   1  compare result, used only with cmp_valid
//   state            out  3  FSM state code
//   digit_count      out  4  digits accepted in the current entry
//   fail_count       out  4  consecutive failed checks
//   unlock           out  1  high exactly while state==OPEN
//   alarm            out  1  high exactly while state==LOCKOUT
//   cmp_req          out  1  pulse in the first CHECK cycle
//   pw_store         out  1  pulse: store buffer as the new password
//   clear_buffer     out  1  pulse: digit buffer must be cleared
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module lock_state_controller #(
    parameter int PW_LEN         = 4,
    parameter int MAX_FAIL       = 3,
    parameter int IDLE_TIMEOUT   = 500,
    parameter int OPEN_CYCLES    = 200,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_on,
    input  logic       digit_strobe,
    input  logic       is_star_pressed,
    input  logic       clear_key,
    input  logic       initialize,
    input  logic       cmp_valid,
    input  logic       correct,
    output logic [2:0] state,
    output logic [3:0] digit_count,
    output logic [3:0] fail_count,
    output logic       unlock,
    output logic       alarm,
    output logic       cmp_req,
    output logic       pw_store,
    output logic       clear_buffer
);

    localparam int MAX_AB = (IDLE_TIMEOUT > OPEN_CYCLES) ? IDLE_TIMEOUT : OPEN_CYCLES;
    localparam int MAX_T  = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [2:0] ST_OFF     = 3'b000;
    localparam logic [2:0] ST_IDLE    = 3'b001;
    localparam logic [2:0] ST_ENTRY   = 3'b010;
    localparam logic [2:0] ST_CHECK   = 3'b011;
    localparam logic [2:0] ST_OPEN    = 3'b100;
    localparam logic [2:0] ST_SET_PW  = 3'b101;
    localparam logic [2:0] ST_LOCKOUT = 3'b110;

    // The state is left on the cycle the timer reads zero, so a load of N-1
    // gives exactly N cycles in the timed state (or N quiet cycles after the
    // last key event).
    localparam logic [TW-1:0] IDLE_RELOAD    = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] OPEN_RELOAD    = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_RELOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO     = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE      = {{(TW-1){1'b0}}, 1'b1};

    localparam logic [3:0] PW_LEN_C   = 4'(PW_LEN);
    localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);
    localparam logic [3:0] CNT_MAX    = 4'd15;

    // Saturating 4-bit increment.
    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        if (val >= lim) begin
            sat_inc = lim;
        end else begin
            sat_inc = val + 4'd1;
        end
    endfunction

    // Timer load value for the state being entered; untimed states load zero.
    function automatic logic [TW-1:0] reload_for(input logic [2:0] st);
        case (st)
            ST_ENTRY, ST_CHECK, ST_SET_PW: reload_for = IDLE_RELOAD;
            ST_OPEN:                       reload_for = OPEN_RELOAD;
            ST_LOCKOUT:                    reload_for = LOCKOUT_RELOAD;
            default:                       reload_for = TIMER_ZERO;
        endcase
    endfunction

    logic [2:0]    state_r;
    logic [3:0]    digit_count_r;
    logic [3:0]    fail_count_r;
    logic [TW-1:0] timer_r;
    logic          unlock_r;
    logic          alarm_r;
    logic          cmp_req_r;
    logic          pw_store_r;
    logic          clear_buffer_r;

    logic [2:0]    state_next_s;
    logic [3:0]    digit_count_next_s;
    logic [3:0]    fail_count_next_s;
    logic [TW-1:0] timer_next_s;
    logic          pw_store_next_s;
    logic          clear_buffer_next_s;
    logic          key_reload_s;
    logic          timer_done_s;
    logic [3:0]    fail_inc_s;
    logic          key_event_s;

    assign timer_done_s = (timer_r == TIMER_ZERO);
    assign fail_inc_s   = sat_inc(fail_count_r, CNT_MAX);
    assign key_event_s  = digit_strobe | is_star_pressed | clear_key;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_next_s        = state_r;
        digit_count_next_s  = digit_count_r;
        fail_count_next_s   = fail_count_r;
        pw_store_next_s     = 1'b0;
        clear_buffer_next_s = 1'b0;
        key_reload_s        = 1'b0;

        // Power-off wins everywhere except LOCKOUT, which always completes.
        // The clear pulse is issued once, on the way into OFF.
        if (!is_on && (state_r != ST_LOCKOUT)) begin
            state_next_s        = ST_OFF;
            digit_count_next_s  = 4'd0;
            clear_buffer_next_s = (state_r != ST_OFF);
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_next_s = ST_IDLE;
                end
                ST_IDLE: begin
                    if (digit_strobe) begin
                        state_next_s       = ST_ENTRY;
                        digit_count_next_s = 4'd1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    key_reload_s = key_event_s;
                    // Submit wins over a digit in the same cycle.
                    if (is_star_pressed) begin
                        state_next_s = ST_CHECK;
                    end else if (clear_key) begin
                        digit_count_next_s  = 4'd0;
                        clear_buffer_next_s = 1'b1;
                    end else if (digit_strobe) begin
                        digit_count_next_s = sat_inc(digit_count_r, PW_LEN_C);
                    end else if (timer_done_s) begin
                        state_next_s        = ST_IDLE;
                        digit_count_next_s  = 4'd0;
                        clear_buffer_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_ENTRY;
                    end
                end
                ST_CHECK: begin
                    if (cmp_valid || timer_done_s) begin
                        digit_count_next_s  = 4'd0;
                        clear_buffer_next_s = 1'b1;
                        // A short entry never passes, even if the compare says so.
                        if (cmp_valid && correct && (digit_count_r == PW_LEN_C)) begin
                            state_next_s      = ST_OPEN;
                            fail_count_next_s = 4'd0;
                        end else begin
                            fail_count_next_s = fail_inc_s;
                            state_next_s      = (fail_inc_s >= MAX_FAIL_C) ? ST_LOCKOUT : ST_IDLE;
                        end
                    end else begin
                        state_next_s = ST_CHECK;
                    end
                end
                ST_OPEN: begin
                    if (initialize) begin
                        state_next_s       = ST_SET_PW;
                        digit_count_next_s = 4'd0;
                    end else if (timer_done_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_OPEN;
                    end
                end
                ST_SET_PW: begin
                    key_reload_s = key_event_s;
                    if (is_star_pressed) begin
                        digit_count_next_s = 4'd0;
                        if (digit_count_r == PW_LEN_C) begin
                            pw_store_next_s = 1'b1;
                            state_next_s    = ST_IDLE;
                        end else begin
                            // Short new password: discard and let the user retry.
                            clear_buffer_next_s = 1'b1;
                        end
                    end else if (clear_key) begin
                        digit_count_next_s  = 4'd0;
                        clear_buffer_next_s = 1'b1;
                    end else if (digit_strobe) begin
                        digit_count_next_s = sat_inc(digit_count_r, PW_LEN_C);
                    end else if (timer_done_s) begin
                        state_next_s        = ST_IDLE;
                        digit_count_next_s  = 4'd0;
                        clear_buffer_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_SET_PW;
                    end
                end
                ST_LOCKOUT: begin
                    // Keys neither act nor extend the lockout.
                    if (timer_done_s) begin
                        fail_count_next_s = 4'd0;
                        state_next_s      = is_on ? ST_IDLE : ST_OFF;
                    end else begin
                        state_next_s = ST_LOCKOUT;
                    end
                end
                default: begin
                    state_next_s       = ST_OFF;
                    digit_count_next_s = 4'd0;
                    fail_count_next_s  = 4'd0;
                end
            endcase
        end
    end

    // Shared timer: reload on a state change or an accepted key, else count down to 0 and hold.
    always_comb begin
        if ((state_next_s != state_r) || key_reload_s) begin
            timer_next_s = reload_for(state_next_s);
        end else if (!timer_done_s) begin
            timer_next_s = timer_r - TIMER_ONE;
        end else begin
            timer_next_s = TIMER_ZERO;
        end
    end

    // State, counters, timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_OFF;
            digit_count_r  <= 4'd0;
            fail_count_r   <= 4'd0;
            timer_r        <= TIMER_ZERO;
            unlock_r       <= 1'b0;
            alarm_r        <= 1'b0;
            cmp_req_r      <= 1'b0;
            pw_store_r     <= 1'b0;
            clear_buffer_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            digit_count_r  <= digit_count_next_s;
            fail_count_r   <= fail_count_next_s;
            timer_r        <= timer_next_s;
            unlock_r       <= (state_next_s == ST_OPEN);
            alarm_r        <= (state_next_s == ST_LOCKOUT);
            cmp_req_r      <= (state_next_s == ST_CHECK) && (state_r != ST_CHECK);
            pw_store_r     <= pw_store_next_s;
            clear_buffer_r <= clear_buffer_next_s;
        end
    end

    assign state        = state_r;
    assign digit_count  = digit_count_r;
    assign fail_count   = fail_count_r;
    assign unlock       = unlock_r;
    assign alarm        = alarm_r;
    assign cmp_req      = cmp_req_r;
    assign pw_store     = pw_store_r;
    assign clear_buffer = clear_buffer_r;

endmodule
